core8_debug_halt_sequencer: RTL and testbench

Coordinates synchronous halt and resume of the eight Nios II cores through their JTAG debug modules. It drives each core's `debugreq`, collects each core's `debugack`, and reports a single system-level halted/resumed status. A debug host can then stop all selected cores together for multi-core inspection. It sits in the Core8 system between the host-side debug control register and the per-core `cpu_N` debug interfaces.

---
 rtl/core8_debug_pkg.sv | 15 +
 rtl/core8_debug_seq_timer.sv | 32 +++
 rtl/core8_debug_halt_sequencer.sv | 156 +++++++++++++++
 tb/tb_core8_debug_halt_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core8_debug_pkg.sv
// Shared types and defaults for the Core8 debug halt sequencer.
// Holds the sequencer state encoding and default core/timeout sizing.
package core8_debug_pkg;

   localparam int CORE8_NUM_CORES      = 8;
   localparam int CORE8_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_HALTED,
      S_RESUME_WAIT
   } dbg_seq_state_t;

endpackage

// File: rtl/core8_debug_seq_timer.sv
// Wait-state watchdog for the debug halt sequencer.
// Flags expiry on the last count of a TIMEOUT_CYCLES window.
module core8_debug_seq_timer
   import core8_debug_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = CORE8_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/core8_debug_halt_sequencer.sv
// Synchronous halt/resume sequencer for the Core8 debug modules.
// Optional wait-state timeout enabled by CORE8_DBG_SEQ_TIMEOUT_EN.
module core8_debug_halt_sequencer
   import core8_debug_pkg::*;
#(
   parameter int NUM_CORES      = CORE8_NUM_CORES,
   parameter int TIMEOUT_CYCLES = CORE8_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 halt_req,
   input  logic                 resume_req,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic [NUM_CORES-1:0] debugack,
   output logic [NUM_CORES-1:0] debugreq,
   output logic                 busy,
   output logic                 all_halted,
   output logic                 done,
   output logic                 timeout,
   output logic [NUM_CORES-1:0] ack_status
);

   generate
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   dbg_seq_state_t       state, state_n;
   logic [NUM_CORES-1:0] active_mask, mask_n;
   logic [NUM_CORES-1:0] acked;
   logic [NUM_CORES-1:0] debugreq_n, ack_n;
   logic                 busy_n, all_halted_n, done_n;

`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
   logic tmr_expired;
   logic tmr_clear;
   logic timeout_n;

   // Restart the window whenever a wait state is freshly entered
   assign tmr_clear = busy_n && (state_n != state);

   core8_debug_seq_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (tmr_clear),
      .enable (busy),
      .expired(tmr_expired)
   );
`endif

   assign acked = debugack & active_mask;

   always_comb begin
      state_n      = state;
      mask_n       = active_mask;
      all_halted_n = all_halted;
      done_n       = 1'b0;
      ack_n        = ack_status;
`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
      timeout_n    = timeout;
`endif
      unique case (state)
         S_IDLE: begin
            if (halt_req) begin
               if (|core_mask) begin
                  mask_n  = core_mask;
                  state_n = S_HALT_WAIT;
`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
                  timeout_n = 1'b0;
`endif
               end else begin
                  done_n = 1'b1;
                  ack_n  = '0;
               end
            end
         end
         S_HALT_WAIT: begin
            if (acked == active_mask) begin
               state_n      = S_HALTED;
               all_halted_n = 1'b1;
               done_n       = 1'b1;
               ack_n        = acked;
`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
            end else if (tmr_expired) begin
               timeout_n = 1'b1;
               state_n   = S_RESUME_WAIT;
`endif
            end
         end
         S_HALTED: begin
            if (resume_req) begin
               all_halted_n = 1'b0;
               state_n      = S_RESUME_WAIT;
            end
         end
         S_RESUME_WAIT: begin
            if (acked == '0) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
               ack_n   = acked;
`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
            end else if (tmr_expired) begin
               timeout_n = 1'b1;
               state_n   = S_IDLE;
               done_n    = 1'b1;
               ack_n     = acked;
`endif
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state, so they move with it
      debugreq_n = ((state_n == S_HALT_WAIT) || (state_n == S_HALTED))
                 ? mask_n : '0;
      busy_n     = (state_n == S_HALT_WAIT) || (state_n == S_RESUME_WAIT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         active_mask <= '0;
         debugreq    <= '0;
         busy        <= 1'b0;
         all_halted  <= 1'b0;
         done        <= 1'b0;
         ack_status  <= '0;
      end else begin
         state       <= state_n;
         active_mask <= mask_n;
         debugreq    <= debugreq_n;
         busy        <= busy_n;
         all_halted  <= all_halted_n;
         done        <= done_n;
         ack_status  <= ack_n;
      end
   end

`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout <= 1'b0;
      end else begin
         timeout <= timeout_n;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core8_debug_halt_sequencer.sv
// Directed bench for core8_debug_halt_sequencer (TIMEOUT_CYCLES=16).
// Timeout scenarios follow CORE8_DBG_SEQ_TIMEOUT_EN.
module tb_core8_debug_halt_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       halt_req;
   logic       resume_req;
   logic [7:0] core_mask;
   logic [7:0] debugack;
   logic [7:0] debugreq;
   logic       busy;
   logic       all_halted;
   logic       done;
   logic       timeout;
   logic [7:0] ack_status;

   int total  = 0;
   int passed = 0;

   core8_debug_halt_sequencer #(
      .NUM_CORES     (8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .halt_req  (halt_req),
      .resume_req(resume_req),
      .core_mask (core_mask),
      .debugack  (debugack),
      .debugreq  (debugreq),
      .busy      (busy),
      .all_halted(all_halted),
      .done      (done),
      .timeout   (timeout),
      .ack_status(ack_status)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " debugreq"}, debugreq, 8'h00);
      chk({tag, " busy"}, {7'b0, busy}, 8'h00);
      chk({tag, " all_halted"}, {7'b0, all_halted}, 8'h00);
      chk({tag, " done"}, {7'b0, done}, 8'h00);
      chk({tag, " timeout"}, {7'b0, timeout}, 8'h00);
      chk({tag, " ack_status"}, ack_status, 8'h00);
   endtask

   initial begin
      reset_n    = 1'b0;
      halt_req   = 1'b0;
      resume_req = 1'b0;
      core_mask  = 8'h00;
      debugack   = 8'h00;
      step();
      step();
      chk_idle("reset");
      reset_n = 1'b1;
      step();
      chk_idle("post_reset");

      // Full-mask halt, acks three cycles after the request
      core_mask = 8'hFF;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      chk("t1 busy", {7'b0, busy}, 8'h01);
      chk("t1 debugreq", debugreq, 8'hFF);
      step();
      step();
      debugack = 8'hFF;
      chk("t1 wait done", {7'b0, done}, 8'h00);
      step();
      chk("t1 done", {7'b0, done}, 8'h01);
      chk("t1 all_halted", {7'b0, all_halted}, 8'h01);
      chk("t1 ack_status", ack_status, 8'hFF);
      chk("t1 busy off", {7'b0, busy}, 8'h00);
      chk("t1 hold req", debugreq, 8'hFF);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("t1 done pulse", {7'b0, done}, 8'h00);
      chk("t1 halt ignored", {7'b0, busy}, 8'h00);
      resume_req = 1'b1;
      step();
      resume_req = 1'b0;
      chk("t1 resume busy", {7'b0, busy}, 8'h01);
      chk("t1 resume req", debugreq, 8'h00);
      chk("t1 resume halted", {7'b0, all_halted}, 8'h00);
      step();
      debugack = 8'h00;
      step();
      chk("t1 resume done", {7'b0, done}, 8'h01);
      chk("t1 resume idle", {7'b0, busy}, 8'h00);
      chk("t1 resume ack", ack_status, 8'h00);
      step();
      chk("t1 resume pulse", {7'b0, done}, 8'h00);

      // Empty mask: immediate done, no sequence
      core_mask = 8'h00;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      chk("t3 done", {7'b0, done}, 8'h01);
      chk("t3 busy", {7'b0, busy}, 8'h00);
      chk("t3 debugreq", debugreq, 8'h00);
      chk("t3 all_halted", {7'b0, all_halted}, 8'h00);
      step();
      chk("t3 pulse", {7'b0, done}, 8'h00);
      chk("t3 busy2", {7'b0, busy}, 8'h00);

      // Simultaneous halt+resume: halt wins
      core_mask  = 8'h03;
      halt_req   = 1'b1;
      resume_req = 1'b1;
      step();
      halt_req   = 1'b0;
      chk("t4 busy", {7'b0, busy}, 8'h01);
      chk("t4 debugreq", debugreq, 8'h03);
      step();
      resume_req = 1'b0;
      chk("t4 ignore resume", debugreq, 8'h03);
      chk("t4 no done", {7'b0, done}, 8'h00);
      debugack = 8'h83;
      step();
      chk("t4 done", {7'b0, done}, 8'h01);
      chk("t4 ack_status", ack_status, 8'h03);
      resume_req = 1'b1;
      step();
      resume_req = 1'b0;
      debugack   = 8'h80;
      step();
      chk("t4 resume done", {7'b0, done}, 8'h01);
      chk("t4 resume busy", {7'b0, busy}, 8'h00);
      debugack = 8'h00;

      // Asynchronous reset during HALT_WAIT
      core_mask = 8'hFF;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      chk("t5 debugreq", debugreq, 8'hFF);
      #2 reset_n = 1'b0;
      #1;
      chk("t5 async req", debugreq, 8'h00);
      chk("t5 async busy", {7'b0, busy}, 8'h00);
      step();
      reset_n = 1'b1;
      step();
      chk_idle("t5 after");

`ifdef CORE8_DBG_SEQ_TIMEOUT_EN
      // Core 2 never acks: abort via timeout in both wait states
      core_mask = 8'h05;
      debugack  = 8'h01;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("t2 last wait", {7'b0, timeout}, 8'h00);
      chk("t2 last req", debugreq, 8'h05);
      step();
      chk("t2 timeout", {7'b0, timeout}, 8'h01);
      chk("t2 req drop", debugreq, 8'h00);
      chk("t2 busy", {7'b0, busy}, 8'h01);
      chk("t2 no done", {7'b0, done}, 8'h00);
      for (int i = 0; i < 15; i++) step();
      chk("t2 rw wait", {7'b0, done}, 8'h00);
      step();
      chk("t2 abort done", {7'b0, done}, 8'h01);
      chk("t2 abort ack", ack_status, 8'h01);
      chk("t2 abort halted", {7'b0, all_halted}, 8'h00);
      chk("t2 abort busy", {7'b0, busy}, 8'h00);
      chk("t2 sticky", {7'b0, timeout}, 8'h01);
      debugack = 8'h00;
      step();

      // Last ack lands exactly in the expiry cycle
      core_mask = 8'h01;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      chk("t6 tmo cleared", {7'b0, timeout}, 8'h00);
      for (int i = 0; i < 15; i++) step();
      debugack = 8'h01;
      step();
      chk("t6 done", {7'b0, done}, 8'h01);
      chk("t6 halted", {7'b0, all_halted}, 8'h01);
      chk("t6 timeout", {7'b0, timeout}, 8'h00);
      chk("t6 req", debugreq, 8'h01);
`else
      // Without the watchdog a very slow ack still completes
      core_mask = 8'h01;
      halt_req  = 1'b1;
      step();
      halt_req = 1'b0;
      for (int i = 0; i < 4999; i++) step();
      chk("t6 still busy", {7'b0, busy}, 8'h01);
      chk("t6 still req", debugreq, 8'h01);
      chk("t6 no timeout", {7'b0, timeout}, 8'h00);
      debugack = 8'h01;
      step();
      chk("t6 done", {7'b0, done}, 8'h01);
      chk("t6 halted", {7'b0, all_halted}, 8'h01);
      chk("t6 timeout", {7'b0, timeout}, 8'h00);
`endif
      resume_req = 1'b1;
      step();
      resume_req = 1'b0;
      debugack   = 8'h00;
      step();
      chk("end done", {7'b0, done}, 8'h01);
      chk("end busy", {7'b0, busy}, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
